// File: rtl/lotr_pkg.sv
// Shared constants, FSM state type and screen-address helper for the VGA text engine.
package lotr_pkg;

    localparam int VGA_WORDS_PER_ROW = 80;
    localparam int VGA_ROW_GROUPS    = 120;
    localparam int VGA_TEXT_COLS     = 80;
    localparam int VGA_TEXT_ROWS     = 60;
    localparam int WORD_IDX_W        = 14;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WR0,
        RD1,
        WR1,
        CLR
    } t_vga_chr_state;

    // A text row spans two row-groups; half selects glyph lines 0-3 or 4-7.
    function automatic logic [WORD_IDX_W-1:0] char_word(
        input logic [6:0] x,
        input logic [5:0] y,
        input logic       half
    );
        logic [WORD_IDX_W-1:0] grp;
        grp = {7'd0, y, half};
        return WORD_IDX_W'(grp * WORD_IDX_W'(VGA_WORDS_PER_ROW)) + {7'd0, x};
    endfunction

endpackage

// File: rtl/vga_font_rom.sv
// 256x32 synchronous glyph ROM: address {code,half}, byte b holds glyph line 4*half+b.
// Glyph lines are generated procedurally: line r = {code,0} ^ (8'h80 >> r).
module vga_font_rom (
    input  logic        clk,
    input  logic [7:0]  addr,
    output logic [31:0] data
);

    function automatic logic [31:0] glyph_word(input logic [7:0] a);
        logic [31:0] w;
        logic [2:0]  r;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            r = {a[0], 2'(b)};
            w[8*b +: 8] = {a[7:1], 1'b0} ^ (8'h80 >> r);
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        data <= glyph_word(addr);
    end

endmodule

// File: rtl/vga_char_writer.sv
// Text engine: renders 8x8 glyphs and screen clears into VGA memory words and
// merges them behind core writes onto the single vga_ctrl write port.
module vga_char_writer
    import lotr_pkg::*;
#(
    parameter logic [31:0] VGA_BASE_ADDR = 32'h0000_0000,
    parameter int          CLR_WORDS     = 9600
) (
    input  logic        QClk,
    input  logic        Reset,
    input  logic        CharReqValid,
    output logic        CharReqReady,
    input  logic [6:0]  CharX,
    input  logic [5:0]  CharY,
    input  logic [6:0]  CharCode,
    input  logic        CharInv,
    input  logic        ClrReqValid,
    input  logic [31:0] ClrPattern,
    input  logic [31:0] CoreWrData,
    input  logic [31:0] CoreWrAddress,
    input  logic [3:0]  CoreWrByteEn,
    input  logic        CoreWrEn,
    output logic [31:0] VgaWrData,
    output logic [31:0] VgaWrAddress,
    output logic [3:0]  VgaWrByteEn,
    output logic        VgaWrEn,
    output logic        Busy,
    output logic        CmdDropped
);

    t_vga_chr_state        state, state_next;
    logic [6:0]            chr_x;
    logic [5:0]            chr_y;
    logic [6:0]            chr_code;
    logic                  chr_inv;
    logic [31:0]           clr_pat;
    logic [WORD_IDX_W-1:0] clr_cnt;
    logic [31:0]           rom_data;
    logic                  eng_en;
    logic [WORD_IDX_W-1:0] eng_word;
    logic [31:0]           eng_data;
    logic                  accept_char, accept_clr, drop;
    logic                  clr_last;

    // ROM address stays fixed through RDn/WRn so stalled writes see stable data.
    vga_font_rom u_font_rom (
        .clk  (QClk),
        .addr ({chr_code, (state == RD1) || (state == WR1)}),
        .data (rom_data)
    );

    assign clr_last = (clr_cnt == WORD_IDX_W'(CLR_WORDS - 1));

    always_comb begin
        state_next  = state;
        eng_en      = 1'b0;
        eng_word    = '0;
        eng_data    = '0;
        accept_char = 1'b0;
        accept_clr  = 1'b0;
        drop        = 1'b0;
        case (state)
            IDLE: begin
                if (ClrReqValid) begin
                    accept_clr = 1'b1;
                    state_next = CLR;
                end else if (CharReqValid) begin
                    if (CharX <= 7'(VGA_TEXT_COLS - 1) && CharY <= 6'(VGA_TEXT_ROWS - 1)) begin
                        accept_char = 1'b1;
                        state_next  = RD0;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            RD0: state_next = WR0;
            WR0: begin
                eng_en   = 1'b1;
                eng_word = char_word(chr_x, chr_y, 1'b0);
                eng_data = rom_data ^ {32{chr_inv}};
                if (!CoreWrEn) state_next = RD1;
            end
            RD1: state_next = WR1;
            WR1: begin
                eng_en   = 1'b1;
                eng_word = char_word(chr_x, chr_y, 1'b1);
                eng_data = rom_data ^ {32{chr_inv}};
                if (!CoreWrEn) state_next = IDLE;
            end
            CLR: begin
                eng_en   = 1'b1;
                eng_word = clr_cnt;
                eng_data = clr_pat;
                if (!CoreWrEn && clr_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge QClk) begin
        if (Reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            CmdDropped <= 1'b0;
        end else begin
            state      <= state_next;
            CmdDropped <= drop;
            if (state == CLR && !CoreWrEn) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end
        end
    end

    // Command payload registers carry no reset; they are only read after a load.
    always_ff @(posedge QClk) begin
        if (accept_char) begin
            chr_x    <= CharX;
            chr_y    <= CharY;
            chr_code <= CharCode;
            chr_inv  <= CharInv;
        end
        if (accept_clr) begin
            clr_pat <= ClrPattern;
        end
    end

    assign CharReqReady = (state == IDLE);
    assign Busy         = (state != IDLE);

    assign VgaWrEn      = CoreWrEn | eng_en;
    assign VgaWrData    = CoreWrEn ? CoreWrData    : eng_data;
    assign VgaWrByteEn  = CoreWrEn ? CoreWrByteEn  : (eng_en ? 4'hF : 4'h0);
    assign VgaWrAddress = CoreWrEn ? CoreWrAddress :
                          (eng_en ? VGA_BASE_ADDR + {18'd0, eng_word, 2'b00} : 32'h0);

endmodule

// File: tb/tb_vga_char_writer.sv
// Randomized bench for vga_char_writer against a slot-queue model of pending engine writes.
module tb_vga_char_writer;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          CLR_WORDS = 9600;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_valid, char_ready, char_inv, clr_valid;
    logic [6:0]  char_x, char_code;
    logic [5:0]  char_y;
    logic [31:0] clr_pattern, core_data, core_addr;
    logic [3:0]  core_be;
    logic        core_en;
    logic [31:0] vga_data, vga_addr;
    logic [3:0]  vga_be;
    logic        vga_en, busy, dropped;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } slot_t;

    slot_t slots[$];
    bit    drop_q   = 1'b0;
    bit    model_ok = 1'b0;

    always #5 clk = ~clk;

    vga_char_writer #(.VGA_BASE_ADDR(BASE), .CLR_WORDS(CLR_WORDS)) dut (
        .QClk          (clk),
        .Reset         (rst),
        .CharReqValid  (char_valid),
        .CharReqReady  (char_ready),
        .CharX         (char_x),
        .CharY         (char_y),
        .CharCode      (char_code),
        .CharInv       (char_inv),
        .ClrReqValid   (clr_valid),
        .ClrPattern    (clr_pattern),
        .CoreWrData    (core_data),
        .CoreWrAddress (core_addr),
        .CoreWrByteEn  (core_be),
        .CoreWrEn      (core_en),
        .VgaWrData     (vga_data),
        .VgaWrAddress  (vga_addr),
        .VgaWrByteEn   (vga_be),
        .VgaWrEn       (vga_en),
        .Busy          (busy),
        .CmdDropped    (dropped)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] glyph(input int code, input int h);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(((code * 2) & 255) ^ (128 >> (4*h + b)));
        return w;
    endfunction

    function automatic logic [31:0] word_addr(input int word);
        return BASE + 32'(word * 4);
    endfunction

    // One clock: compare outputs in the low phase, then advance the model at the edge.
    task automatic tick();
        bit          eng, was_empty;
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        slot_t       s;
        #1;
        if (model_ok) begin
            eng = (slots.size() > 0) && slots[0].is_wr;
            ea  = core_en ? core_addr : (eng ? slots[0].addr : 32'h0);
            ed  = core_en ? core_data : (eng ? slots[0].data : 32'h0);
            eb  = core_en ? core_be   : (eng ? 4'hF : 4'h0);
            check("wr_en_be_addr", {27'd0, vga_en, vga_be, vga_addr}, {27'd0, core_en | eng, eb, ea});
            check("wr_data", {32'd0, vga_data}, {32'd0, ed});
            check("ready_busy_drop", {61'd0, char_ready, busy, dropped},
                  {61'd0, slots.size() == 0, slots.size() != 0, drop_q});
        end
        @(posedge clk);
        if (rst) begin
            slots.delete();
            drop_q   = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            was_empty = (slots.size() == 0);
            if (!was_empty && (!slots[0].is_wr || !core_en)) void'(slots.pop_front());
            drop_q = 1'b0;
            if (was_empty && clr_valid) begin
                for (int i = 0; i < CLR_WORDS; i++) begin
                    s.is_wr = 1'b1; s.addr = word_addr(i); s.data = clr_pattern;
                    slots.push_back(s);
                end
            end else if (was_empty && char_valid) begin
                if (char_x < 80 && char_y < 60) begin
                    for (int h = 0; h < 2; h++) begin
                        s.is_wr = 1'b0; s.addr = '0; s.data = '0;
                        slots.push_back(s);
                        s.is_wr = 1'b1;
                        s.addr  = word_addr((2*int'(char_y) + h) * 80 + int'(char_x));
                        s.data  = glyph(int'(char_code), h) ^ {32{char_inv}};
                        slots.push_back(s);
                    end
                end else begin
                    drop_q = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        char_valid = 0; clr_valid = 0; core_en = 0;
        core_data = '0; core_addr = '0; core_be = '0;
    endtask

    task automatic send_char(input int x, input int y, input int code, input bit inv);
        char_valid = 1; char_x = 7'(x); char_y = 6'(y); char_code = 7'(code); char_inv = inv;
        tick();
        char_valid = 0;
    endtask

    task automatic random_core();
        core_en   = 1'b1;
        core_data = $urandom;
        core_addr = $urandom;
        core_be   = 4'($urandom_range(0, 15));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (slots.size() != 0 && n < budget) begin tick(); n++; end
        if (slots.size() != 0) check("drain_timeout", 64'(slots.size()), 64'd0);
        tick();
    endtask

    initial begin
        rst = 1; idle_inputs();
        char_x = '0; char_y = '0; char_code = '0; char_inv = 0; clr_pattern = '0;
        @(negedge clk);
        tick(); tick();
        rst = 0;
        tick(); tick();

        // 'A' at the origin, then the bottom-right cell in inverse video.
        send_char(0, 0, 8'h41, 0);   drain(20);
        send_char(79, 59, 8'h5A, 1); drain(20);

        // Out-of-range coordinates are dropped.
        send_char(80, 0, 7, 0);  tick(); tick();
        send_char(3, 60, 9, 0);  tick(); tick();

        // Clear and char in the same cycle: clear wins.
        clr_pattern = 32'hA5A5_A5A5; clr_valid = 1;
        char_valid = 1; char_x = 7'd5; char_y = 6'd5; char_code = 7'd66;
        tick();
        clr_valid = 0; char_valid = 0;
        drain(CLR_WORDS + 10);

        // Core traffic held three cycles across WR0.
        send_char(17, 23, 99, 0);
        tick();
        for (int i = 0; i < 3; i++) begin random_core(); tick(); end
        idle_inputs();
        drain(20);

        // Reset in the cycle that writes clear word 100, then a fresh clear.
        clr_pattern = 32'h1234_5678; clr_valid = 1; tick(); clr_valid = 0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1; tick(); rst = 0;
        clr_pattern = 32'hCAFE_F00D; clr_valid = 1; tick(); clr_valid = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) random_core(); else core_en = 0;
            tick();
        end
        core_en = 0;
        rst = 1; tick(); rst = 0; tick();

        // Random mix of char commands and core writes.
        for (int i = 0; i < 1500; i++) begin
            char_valid = ($urandom_range(0, 2) == 0);
            char_x     = 7'($urandom_range(0, 85));
            char_y     = 6'($urandom_range(0, 63));
            char_code  = 7'($urandom_range(0, 127));
            char_inv   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) random_core(); else core_en = 0;
            tick();
        end
        idle_inputs();
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
